// File: rtl/bus_pkg.sv
// Shared types and helpers for the split-transaction bus arbiter.
package bus_pkg;

    localparam int NUM_INIT = 2;
    localparam int IDW      = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_GRANT       = 2'd1,
        ARB_SPLIT_GRANT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] idx;
    } pick_t;

    // First set bit of mask, searching upward from start and wrapping past NUM_INIT-1.
    function automatic pick_t rr_pick(input logic [NUM_INIT-1:0] mask,
                                      input logic [IDW-1:0]      start);
        pick_t          res;
        logic [IDW-1:0] j_v;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < NUM_INIT; k++) begin
            j_v = IDW'((int'(start) + k) % NUM_INIT);
            if (!res.found && mask[j_v]) begin
                res.found = 1'b1;
                res.idx   = j_v;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_split_arbiter_if.sv
// Arbitration and split-transaction signals between initiators, targets and the arbiter.
interface bus_split_arbiter_if #(
    parameter int NUM_INIT = 2
);
    localparam int IDW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    logic [NUM_INIT-1:0] req;
    logic [NUM_INIT-1:0] grant;
    logic [IDW-1:0]      owner_id;
    logic                bus_busy;
    logic                target_ack;
    logic                target_split_ack;
    logic                split_req;
    logic                split_target_ack;
    logic                split_grant;
    logic                split_pending;
    logic [IDW-1:0]      split_owner;
    logic                split_err;

    modport slave (
        input  req, target_ack, target_split_ack, split_req, split_target_ack,
        output grant, owner_id, bus_busy, split_grant, split_pending, split_owner, split_err
    );

    modport master (
        output req, target_ack, target_split_ack, split_req, split_target_ack,
        input  grant, owner_id, bus_busy, split_grant, split_pending, split_owner, split_err
    );

endinterface

// File: rtl/bus_split_arbiter.sv
// Round-robin arbiter for one bus segment with single-outstanding split transaction
// sequencing (park owner on split ack, hand bus to split target on split_req).
module bus_split_arbiter #(
    parameter int NUM_INIT = bus_pkg::NUM_INIT
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_split_arbiter_if.slave  bus
);
    localparam int IDW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    bus_pkg::arb_state_t state_r;
    logic [NUM_INIT-1:0] grant_r;
    logic [IDW-1:0]      owner_id_r;
    logic [IDW-1:0]      rr_ptr_r;
    logic                split_grant_r;
    logic                split_pending_r;
    logic [IDW-1:0]      split_owner_r;
    logic                split_err_r;

    logic [NUM_INIT-1:0] park_mask_s;
    logic [NUM_INIT-1:0] elig_s;
    bus_pkg::pick_t      pick_s;
    logic [NUM_INIT-1:0] one_s;

    // Mask out the parked initiator so its held req cannot win arbitration.
    always_comb begin
        park_mask_s = '0;
        if (split_pending_r) begin
            park_mask_s[split_owner_r] = 1'b1;
        end else begin
            park_mask_s = '0;
        end
    end

    assign elig_s = bus.req & ~park_mask_s;
    assign pick_s = bus_pkg::rr_pick(elig_s, rr_ptr_r);
    assign one_s  = {{(NUM_INIT-1){1'b0}}, 1'b1};

    // Arbitration and split sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= bus_pkg::ARB_IDLE;
            grant_r         <= '0;
            owner_id_r      <= '0;
            rr_ptr_r        <= '0;
            split_grant_r   <= 1'b0;
            split_pending_r <= 1'b0;
            split_owner_r   <= '0;
            split_err_r     <= 1'b0;
        end else begin
            split_err_r <= 1'b0;
            if (bus.split_req && !split_pending_r) begin
                split_err_r <= 1'b1;
            end
            // Write-path split completion: target acks without ever asking for the bus.
            if (bus.split_target_ack && split_pending_r && (state_r != bus_pkg::ARB_SPLIT_GRANT)) begin
                split_pending_r <= 1'b0;
            end

            case (state_r)
                bus_pkg::ARB_IDLE: begin
                    if (bus.split_req && split_pending_r) begin
                        split_grant_r <= 1'b1;
                        state_r       <= bus_pkg::ARB_SPLIT_GRANT;
                    end else if (pick_s.found) begin
                        grant_r    <= one_s << pick_s.idx;
                        owner_id_r <= pick_s.idx;
                        if (pick_s.idx == IDW'(NUM_INIT - 1)) begin
                            rr_ptr_r <= '0;
                        end else begin
                            rr_ptr_r <= pick_s.idx + 1'b1;
                        end
                        state_r <= bus_pkg::ARB_GRANT;
                    end else begin
                        state_r <= bus_pkg::ARB_IDLE;
                    end
                end

                bus_pkg::ARB_GRANT: begin
                    if (bus.target_split_ack) begin
                        grant_r <= '0;
                        state_r <= bus_pkg::ARB_IDLE;
                        if (!split_pending_r) begin
                            split_pending_r <= 1'b1;
                            split_owner_r   <= owner_id_r;
                        end else begin
                            split_err_r <= 1'b1;
                        end
                    end else if (!bus.req[owner_id_r] || bus.target_ack) begin
                        grant_r <= '0;
                        state_r <= bus_pkg::ARB_IDLE;
                    end else begin
                        state_r <= bus_pkg::ARB_GRANT;
                    end
                end

                bus_pkg::ARB_SPLIT_GRANT: begin
                    if (bus.split_target_ack) begin
                        split_grant_r   <= 1'b0;
                        split_pending_r <= 1'b0;
                        state_r         <= bus_pkg::ARB_IDLE;
                    end else if (!bus.split_req) begin
                        split_grant_r <= 1'b0;
                        split_err_r   <= 1'b1;
                        state_r       <= bus_pkg::ARB_IDLE;
                    end else begin
                        state_r <= bus_pkg::ARB_SPLIT_GRANT;
                    end
                end

                default: begin
                    grant_r       <= '0;
                    split_grant_r <= 1'b0;
                    state_r       <= bus_pkg::ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_r;
    assign bus.owner_id      = owner_id_r;
    assign bus.bus_busy      = (|grant_r) | split_grant_r;
    assign bus.split_grant   = split_grant_r;
    assign bus.split_pending = split_pending_r;
    assign bus.split_owner   = split_owner_r;
    assign bus.split_err     = split_err_r;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Directed testbench for bus_split_arbiter with hand-computed expectations.
module tb_bus_split_arbiter;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;

    bus_split_arbiter_if #(.NUM_INIT(2)) bif();

    bus_split_arbiter #(.NUM_INIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] one_v;
        int          own_v;
        total_cnt = 0;
        bad_cnt   = 0;
        one_v     = 32'd1;
        rst_n     = 1'b0;
        bif.req              = 2'b00;
        bif.target_ack       = 1'b0;
        bif.target_split_ack = 1'b0;
        bif.split_req        = 1'b0;
        bif.split_target_ack = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bif.grant), 32'd0);
        chk("rst_owner", 32'(bif.owner_id), 32'd0);
        chk("rst_busy", 32'(bif.bus_busy), 32'd0);
        chk("rst_sgrant", 32'(bif.split_grant), 32'd0);
        chk("rst_spend", 32'(bif.split_pending), 32'd0);
        chk("rst_sowner", 32'(bif.split_owner), 32'd0);
        chk("rst_serr", 32'(bif.split_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, one-cycle grant latency, release on req low
        bif.req = 2'b01;
        tick();
        chk("t1_grant", 32'(bif.grant), 32'd1);
        chk("t1_owner", 32'(bif.owner_id), 32'd0);
        chk("t1_busy", 32'(bif.bus_busy), 32'd1);
        bif.req = 2'b00;
        tick();
        chk("t1_release", 32'(bif.grant), 32'd0);
        chk("t1_idle_busy", 32'(bif.bus_busy), 32'd0);

        // Round-robin alternation with an idle cycle between owners
        do_reset();
        bif.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            own_v = i % 2;
            tick();
            chk("t2_grant", 32'(bif.grant), one_v << own_v);
            chk("t2_owner", 32'(bif.owner_id), 32'(own_v));
            tick();
            tick();
            chk("t2_hold", 32'(bif.grant), one_v << own_v);
            bif.req[own_v] = 1'b0;
            tick();
            chk("t2_gap", 32'(bif.grant), 32'd0);
            bif.req[own_v] = 1'b1;
        end
        bif.req = 2'b00;
        tick();

        // Write split parks owner 1, owner 0 served, write-path completion clears pending
        do_reset();
        bif.req = 2'b10;
        tick();
        chk("t3_grant1", 32'(bif.grant), 32'd2);
        bif.req = 2'b11;
        bif.target_split_ack = 1'b1;
        tick();
        bif.target_split_ack = 1'b0;
        chk("t3_park_grant", 32'(bif.grant), 32'd0);
        chk("t3_pending", 32'(bif.split_pending), 32'd1);
        chk("t3_sowner", 32'(bif.split_owner), 32'd1);
        tick();
        chk("t3_grant0", 32'(bif.grant), 32'd1);
        bif.split_target_ack = 1'b1;
        tick();
        bif.split_target_ack = 1'b0;
        chk("t3_pend_clr", 32'(bif.split_pending), 32'd0);
        chk("t3_grant0_kept", 32'(bif.grant), 32'd1);
        chk("t3_no_err", 32'(bif.split_err), 32'd0);
        bif.target_ack = 1'b1;
        tick();
        bif.target_ack = 1'b0;
        chk("t3_ack_release", 32'(bif.grant), 32'd0);
        bif.req = 2'b00;
        tick();

        // Read split: split_req wins over pending req, then parked initiator released
        do_reset();
        bif.req = 2'b01;
        tick();
        chk("t4_grant0", 32'(bif.grant), 32'd1);
        bif.target_split_ack = 1'b1;
        tick();
        bif.target_split_ack = 1'b0;
        chk("t4_pending", 32'(bif.split_pending), 32'd1);
        chk("t4_sowner", 32'(bif.split_owner), 32'd0);
        bif.req = 2'b11;
        bif.split_req = 1'b1;
        tick();
        chk("t4_sgrant", 32'(bif.split_grant), 32'd1);
        chk("t4_sg_nogrant", 32'(bif.grant), 32'd0);
        chk("t4_sg_busy", 32'(bif.bus_busy), 32'd1);
        tick();
        chk("t4_sg_hold", 32'(bif.split_grant), 32'd1);
        bif.split_target_ack = 1'b1;
        bif.split_req = 1'b0;
        tick();
        bif.split_target_ack = 1'b0;
        chk("t4_sg_drop", 32'(bif.split_grant), 32'd0);
        chk("t4_pend_clr", 32'(bif.split_pending), 32'd0);
        chk("t4_no_err", 32'(bif.split_err), 32'd0);
        tick();
        chk("t4_grant1", 32'(bif.grant), 32'd2);
        chk("t4_owner1", 32'(bif.owner_id), 32'd1);
        bif.req = 2'b00;
        tick();

        // split_req without a pending split
        bif.split_req = 1'b1;
        tick();
        chk("t5_orphan_err", 32'(bif.split_err), 32'd1);
        chk("t5_orphan_sg", 32'(bif.split_grant), 32'd0);
        chk("t5_orphan_grant", 32'(bif.grant), 32'd0);
        bif.split_req = 1'b0;
        tick();
        chk("t5_err_pulse", 32'(bif.split_err), 32'd0);

        // Second split ack while one is outstanding
        do_reset();
        bif.req = 2'b01;
        tick();
        bif.target_split_ack = 1'b1;
        tick();
        bif.target_split_ack = 1'b0;
        bif.req = 2'b10;
        tick();
        chk("t5_grant1", 32'(bif.grant), 32'd2);
        bif.target_split_ack = 1'b1;
        tick();
        bif.target_split_ack = 1'b0;
        chk("t5_dbl_err", 32'(bif.split_err), 32'd1);
        chk("t5_dbl_grant", 32'(bif.grant), 32'd0);
        chk("t5_dbl_sowner", 32'(bif.split_owner), 32'd0);
        chk("t5_dbl_pend", 32'(bif.split_pending), 32'd1);
        bif.req = 2'b00;
        tick();
        chk("t5_dbl_pulse", 32'(bif.split_err), 32'd0);

        // split_req withdrawn before the split target acks
        bif.split_req = 1'b1;
        tick();
        chk("t5_sg_on", 32'(bif.split_grant), 32'd1);
        bif.split_req = 1'b0;
        tick();
        chk("t5_abort_sg", 32'(bif.split_grant), 32'd0);
        chk("t5_abort_err", 32'(bif.split_err), 32'd1);
        chk("t5_abort_pend", 32'(bif.split_pending), 32'd1);

        // Asynchronous reset during split grant
        bif.split_req = 1'b1;
        tick();
        chk("t6_sg_on", 32'(bif.split_grant), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_sg", 32'(bif.split_grant), 32'd0);
        chk("t6_async_grant", 32'(bif.grant), 32'd0);
        chk("t6_async_pend", 32'(bif.split_pending), 32'd0);
        chk("t6_async_busy", 32'(bif.bus_busy), 32'd0);
        bif.split_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
